// File: rtl/fmdsp_mac_pipe.sv
// Pipelined multi-precision multiply-accumulate with per-mode latency,
// valid/ready issue, in-order completion, shifted-accumulator feedback and saturation.
module fmdsp_mac_pipe #(
    parameter int N     = 9,
    parameter int M     = 9,
    parameter int ACC_W = 18,
    parameter int SHW   = 2,
    parameter int LAT0  = 1,
    parameter int LAT1  = 2,
    parameter int LAT2  = 4,
    parameter int LAT3  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     aa,
    input  logic [M-1:0]     bb,
    input  logic [ACC_W-1:0] cc,
    input  logic             mac,
    input  logic [SHW-1:0]   shift,
    input  logic             sat_en,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] out,
    output logic             out_valid,
    output logic             ovf
);

    localparam int N2     = N / 2;
    localparam int M2     = M / 2;
    localparam int SW     = ACC_W + 1;
    localparam int LMAX01 = (LAT0 > LAT1) ? LAT0 : LAT1;
    localparam int LMAX23 = (LAT2 > LAT3) ? LAT2 : LAT3;
    localparam int LATMAX = (LMAX01 > LMAX23) ? LMAX01 : LMAX23;
    localparam int DEPTH  = (LATMAX > 1) ? LATMAX - 1 : 1;
    localparam int REM_W  = $clog2(LATMAX + 1);

    typedef struct packed {
        logic             vld;
        logic [ACC_W-1:0] prod;
        logic [ACC_W-1:0] cc;
        logic             mac;
        logic [SHW-1:0]   shift;
        logic             sat_en;
    } op_t;

    logic [REM_W-1:0]   rem_q, rem_d, lat_sel;
    op_t [DEPTH-1:0]    pipe_q, pipe_d;
    logic [ACC_W-1:0]   out_q, out_d, acc_q, acc_d;
    logic               out_valid_q, out_valid_d, ovf_q, ovf_d;

    logic               accept, imm, comp, ovf_w;
    op_t                new_op, cop;
    logic signed [ACC_W-1:0] a_lo, a_hi, a_full, b_lo, b_hi, b_full, prod_w;
    logic signed [ACC_W-1:0] acc_shr, addend;
    logic [SW-1:0]      sum;
    logic [ACC_W-1:0]   sat_val, res;

    always_comb begin
        case (mode)
            2'b00:   lat_sel = REM_W'(LAT0);
            2'b01:   lat_sel = REM_W'(LAT1);
            2'b10:   lat_sel = REM_W'(LAT2);
            default: lat_sel = REM_W'(LAT3);
        endcase
        in_ready = (rem_q < lat_sel);
        accept   = in_valid && in_ready;
    end

    // Operand fields sign-extended to ACC_W; every product form fits exactly there.
    always_comb begin
        a_lo   = {{(ACC_W-N2-1){aa[N2]}}, aa[N2:0]};
        a_hi   = {{(ACC_W-N+N2+1){aa[N-1]}}, aa[N-1:N2+1]};
        a_full = {{(ACC_W-N){aa[N-1]}}, aa};
        b_lo   = {{(ACC_W-M2-1){bb[M2]}}, bb[M2:0]};
        b_hi   = {{(ACC_W-M+M2+1){bb[M-1]}}, bb[M-1:M2+1]};
        b_full = {{(ACC_W-M){bb[M-1]}}, bb};
        case (mode)
            2'b00:   prod_w = a_lo * b_lo;
            2'b01:   prod_w = a_lo * b_full;
            2'b10:   prod_w = a_full * b_full;
            default: prod_w = a_hi * b_hi + a_lo * b_lo;
        endcase
        new_op        = '0;
        new_op.vld    = 1'b1;
        new_op.prod   = prod_w;
        new_op.cc     = cc;
        new_op.mac    = mac;
        new_op.shift  = shift;
        new_op.sat_en = sat_en;
    end

    // Slot k holds the op that completes k edges after the next one;
    // a latency-1 op bypasses the slots and completes at its accept edge.
    always_comb begin
        rem_d = '0;
        if (accept) begin
            rem_d = lat_sel - REM_W'(1);
        end else if (rem_q != '0) begin
            rem_d = rem_q - REM_W'(1);
        end
        pipe_d = '0;
        for (int unsigned k = 0; k < DEPTH - 1; k++) begin
            pipe_d[k] = pipe_q[k+1];
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (accept && (int'(lat_sel) == int'(k) + 2)) begin
                pipe_d[k] = new_op;
            end
        end
        imm  = accept && (lat_sel == REM_W'(1));
        cop  = imm ? new_op : pipe_q[0];
        comp = imm || pipe_q[0].vld;
    end

    always_comb begin
        acc_shr = $signed(acc_q) >>> cop.shift;
        addend  = cop.mac ? acc_shr : $signed(cop.cc);
        sum     = {cop.prod[ACC_W-1], cop.prod} + {addend[ACC_W-1], addend};
        ovf_w   = sum[SW-1] ^ sum[SW-2];
        sat_val = sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        res     = (ovf_w && cop.sat_en) ? sat_val : sum[ACC_W-1:0];

        out_d       = comp ? res : out_q;
        out_valid_d = comp;
        ovf_d       = comp && ovf_w;
        if (acc_clr) begin
            acc_d = '0;
        end else if (comp) begin
            acc_d = res;
        end else begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            pipe_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            rem_q       <= rem_d;
            pipe_q      <= pipe_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fmdsp_mac_pipe.sv
// Self-checking bench for fmdsp_mac_pipe: directed scenarios plus random traffic
// compared against a cycle-indexed queue model of the arithmetic and issue rules.
module tb_fmdsp_mac_pipe;

    localparam int N     = 9;
    localparam int M     = 9;
    localparam int ACC_W = 18;
    localparam int SHW   = 2;
    localparam int LO_A  = N / 2 + 1;
    localparam int HI_A  = N - LO_A;
    localparam int LO_B  = M / 2 + 1;
    localparam int HI_B  = M - LO_B;
    localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W - 1));

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [N-1:0]     aa;
    logic [M-1:0]     bb;
    logic [ACC_W-1:0] cc;
    logic             mac;
    logic [SHW-1:0]   shift;
    logic             sat_en;
    logic             acc_clr;
    logic [ACC_W-1:0] out;
    logic             out_valid;
    logic             ovf;

    fmdsp_mac_pipe #(
        .N(N), .M(M), .ACC_W(ACC_W), .SHW(SHW),
        .LAT0(1), .LAT1(2), .LAT2(4), .LAT3(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .aa(aa), .bb(bb), .cc(cc), .mac(mac), .shift(shift),
        .sat_en(sat_en), .acc_clr(acc_clr), .out(out), .out_valid(out_valid),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint due;
        int     mode;
        int     aa;
        int     bb;
        int     cc;
        bit     mac;
        int     shift;
        bit     sat;
    } op_t;

    op_t    q[$];
    longint cyc = 0;
    longint last_due;
    longint m_acc;
    longint exp_out;
    bit     exp_valid;
    bit     exp_ovf;
    int     n_checks = 0;
    int     n_fail = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int lat_of(input int md);
        case (md)
            0: return 1;
            1: return 2;
            2: return 4;
            default: return 4;
        endcase
    endfunction

    function automatic longint sfield(input int v, input int lsb, input int w);
        longint x;
        x = (longint'(v) >> lsb) & ((longint'(1) << w) - 1);
        if (x >= (longint'(1) << (w - 1))) x -= (longint'(1) << w);
        return x;
    endfunction

    function automatic longint product(input op_t o);
        longint alo, ahi, afu, blo, bhi, bfu;
        alo = sfield(o.aa, 0, LO_A);
        ahi = sfield(o.aa, LO_A, HI_A);
        afu = sfield(o.aa, 0, N);
        blo = sfield(o.bb, 0, LO_B);
        bhi = sfield(o.bb, LO_B, HI_B);
        bfu = sfield(o.bb, 0, M);
        case (o.mode)
            0: return alo * blo;
            1: return alo * bfu;
            2: return afu * bfu;
            default: return ahi * bhi + alo * blo;
        endcase
    endfunction

    task automatic reset_model();
        q.delete();
        m_acc     = 0;
        exp_out   = 0;
        exp_valid = 0;
        exp_ovf   = 0;
        last_due  = -1;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit     rdy, comp;
        longint sum, res;
        op_t    o;
        @(negedge clk);
        check("out_valid", longint'(out_valid), longint'(exp_valid));
        check("out", longint'($signed(out)), exp_out);
        if (exp_valid) check("ovf", longint'(ovf), longint'(exp_ovf));
        rdy = (cyc + lat_of(int'(mode)) > last_due);
        check("in_ready", longint'(in_ready), longint'(rdy));
        @(posedge clk);
        if (rst_n) begin
            if (in_valid && rdy) begin
                o.due = cyc + lat_of(int'(mode));
                o.mode = int'(mode);
                o.aa = int'(aa);
                o.bb = int'(bb);
                o.cc = int'(cc);
                o.mac = mac;
                o.shift = int'(shift);
                o.sat = sat_en;
                q.push_back(o);
                last_due = o.due;
            end
            comp = (q.size() > 0) && (q[0].due == cyc + 1);
            res = 0;
            if (comp) begin
                o = q.pop_front();
                sum = product(o) + (o.mac ? (m_acc >>> o.shift) : sfield(o.cc, 0, ACC_W));
                exp_ovf = (sum > MAXV) || (sum < MINV);
                if (exp_ovf && o.sat) begin
                    res = (sum > MAXV) ? MAXV : MINV;
                end else begin
                    res = sfield(int'(sum & ((longint'(1) << ACC_W) - 1)), 0, ACC_W);
                end
                exp_out = res;
            end
            exp_valid = comp;
            if (acc_clr) m_acc = 0;
            else if (comp) m_acc = res;
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input int md, input int a, input int b, input int c,
                         input bit mc, input int sh, input bit st);
        mode   = 2'(md);
        aa     = N'(a);
        bb     = M'(b);
        cc     = ACC_W'(c);
        mac    = mc;
        shift  = SHW'(sh);
        sat_en = st;
    endtask

    task automatic issue(input int md, input int a, input int b, input int c,
                         input bit mc, input int sh, input bit st);
        drive(md, a, b, c, mc, sh, st);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        acc_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        reset_model();
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Mode 10 latency and result
        issue(2, -3, 100, 5, 0, 0, 0);
        idle(5);
        check("t1_out", longint'($signed(out)), -295);

        // Accumulate chain, clear, rechain
        issue(0, 3, 4, 0, 0, 0, 0);
        idle(1);
        check("t2_first", longint'($signed(out)), 12);
        issue(0, 2, 5, 0, 1, 1, 0);
        idle(1);
        check("t2_chain", longint'($signed(out)), 16);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        issue(0, 1, 1, 0, 1, 0, 0);
        idle(1);
        check("t2_clr", longint'($signed(out)), 1);

        // Short op offered behind a long one
        issue(2, 7, 9, 1, 0, 0, 0);
        drive(0, 5, 6, 2, 0, 0, 0);
        in_valid = 1'b1;
        idle(4);
        in_valid = 1'b0;
        idle(3);
        check("t3_out", longint'($signed(out)), 32);

        // Saturation and wrap
        issue(2, -256, -256, 131071, 0, 0, 1);
        idle(5);
        check("t4_sat", longint'($signed(out)), 131071);
        issue(2, -256, -256, 131071, 0, 0, 0);
        idle(5);
        check("t4_wrap", longint'($signed(out)), -65537);

        // Dual-lane dot product
        issue(3, 67, 484, 0, 0, 0, 0);
        idle(5);
        check("t5_dot", longint'($signed(out)), 10);

        // Reset while an op is in flight
        issue(2, 11, 13, 0, 0, 0, 0);
        tick();
        rst_n = 1'b0;
        reset_model();
        tick();
        rst_n = 1'b1;
        idle(6);
        check("t6_out", longint'($signed(out)), 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            in_valid = ($urandom_range(0, 9) < 6);
            mode     = 2'($urandom_range(0, 3));
            aa       = N'($urandom);
            bb       = M'($urandom);
            if ($urandom_range(0, 3) == 0)
                cc = $urandom_range(0, 1) ? ACC_W'(18'h1FFFF) : ACC_W'(18'h20000);
            else
                cc = ACC_W'($urandom);
            mac      = 1'($urandom_range(0, 1));
            shift    = SHW'($urandom_range(0, 3));
            sat_en   = 1'($urandom_range(0, 1));
            acc_clr  = ($urandom_range(0, 9) == 0);
            tick();
        end
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
